instr_fetch_unit: RTL and testbench

Front-end fetch stage that drives the IF/ID pipeline register. It owns the program counter and issues word requests to instruction memory over a req/ack handshake. It buffers one fetched instruction and presents it as `instr_o`/`instrAddr_o`, honouring the same `hazardDetected_i` (stall) and `IFFlush_i` (redirect) signals that the IF/ID register consumes. When no instruction is available, it presents an all-zero bubble.

---
 rtl/instr_fetch_unit.sv | 134 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues req/ack word fetches, buffers one instruction for IF/ID.
// Ack at edge N gives valid instr_o in cycle N+1; stalls hold the buffer and withhold new requests.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hazardDetected_i,
  input  logic        IFFlush_i,
  input  logic [31:0] branchTarget_i,
  output logic        imemReq_o,
  output logic [31:0] imemAddr_o,
  input  logic        imemAck_i,
  input  logic [31:0] imemData_i,
  output logic [31:0] instr_o,
  output logic [31:0] instrAddr_o,
  output logic        instrValid_o
);

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] redir_pc, redir_pc_nxt;
  logic [31:0] buf_instr, buf_instr_nxt;
  logic [31:0] buf_addr, buf_addr_nxt;
  logic        buf_valid, buf_valid_nxt;
  logic [31:0] target;
  logic        req_raw;
  logic        ack;

  assign target  = branchTarget_i & 32'hFFFF_FFFC;
  // In FULL a new fetch is only requested when the buffer is being consumed.
  assign req_raw = (state == FULL) ? !hazardDetected_i : 1'b1;
  assign ack     = req_raw & imemAck_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= REQ;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc        <= RESET_PC;
      redir_pc  <= 32'h0;
      buf_instr <= 32'h0;
      buf_addr  <= 32'h0;
      buf_valid <= 1'b0;
    end else begin
      pc        <= pc_nxt;
      redir_pc  <= redir_pc_nxt;
      buf_instr <= buf_instr_nxt;
      buf_addr  <= buf_addr_nxt;
      buf_valid <= buf_valid_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    redir_pc_nxt  = redir_pc;
    buf_instr_nxt = buf_instr;
    buf_addr_nxt  = buf_addr;
    buf_valid_nxt = buf_valid;
    case (state)
      REQ: begin
        if (IFFlush_i) begin
          if (ack) begin
            pc_nxt = target;
          end else begin
            redir_pc_nxt = target;
            state_nxt    = DRAIN;
          end
        end else if (ack) begin
          buf_instr_nxt = imemData_i;
          buf_addr_nxt  = pc;
          buf_valid_nxt = 1'b1;
          pc_nxt        = pc + 32'd4;
          state_nxt     = FULL;
        end
      end
      FULL: begin
        if (IFFlush_i) begin
          buf_valid_nxt = 1'b0;
          // An unanswered request cannot be aborted, so its reply must be drained first.
          if (!req_raw || ack) begin
            pc_nxt    = target;
            state_nxt = REQ;
          end else begin
            redir_pc_nxt = target;
            state_nxt    = DRAIN;
          end
        end else if (!hazardDetected_i) begin
          if (ack) begin
            buf_instr_nxt = imemData_i;
            buf_addr_nxt  = pc;
            pc_nxt        = pc + 32'd4;
          end else begin
            buf_valid_nxt = 1'b0;
            state_nxt     = REQ;
          end
        end
      end
      DRAIN: begin
        if (ack) begin
          pc_nxt    = IFFlush_i ? target : redir_pc;
          state_nxt = REQ;
        end else if (IFFlush_i) begin
          redir_pc_nxt = target;
        end
      end
      default: begin
        state_nxt     = REQ;
        buf_valid_nxt = 1'b0;
      end
    endcase
  end

  always_comb begin
    imemReq_o    = req_raw & !rst_i;
    imemAddr_o   = rst_i ? 32'h0 : pc;
    instr_o      = buf_valid ? buf_instr : 32'h0;
    instrAddr_o  = buf_valid ? buf_addr : 32'h0;
    instrValid_o = buf_valid;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: wait-state memory, request-level reference model, directed scenarios.
module tb_instr_fetch_unit;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        hazardDetected_i;
  logic        IFFlush_i;
  logic [31:0] branchTarget_i;
  logic        imemReq_o;
  logic [31:0] imemAddr_o;
  logic        imemAck_i;
  logic [31:0] imemData_i;
  logic [31:0] instr_o;
  logic [31:0] instrAddr_o;
  logic        instrValid_o;

  always #5 clk_i = ~clk_i;

  instr_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .hazardDetected_i (hazardDetected_i),
    .IFFlush_i        (IFFlush_i),
    .branchTarget_i   (branchTarget_i),
    .imemReq_o        (imemReq_o),
    .imemAddr_o       (imemAddr_o),
    .imemAck_i        (imemAck_i),
    .imemData_i       (imemData_i),
    .instr_o          (instr_o),
    .instrAddr_o      (instrAddr_o),
    .instrValid_o     (instrValid_o)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int ws     = 0;
  int wcnt   = 0;

  // Reference model: fetch PC, one-entry buffer, and whether the outstanding reply is stale.
  logic [31:0] m_pc, m_redir, m_buf, m_baddr;
  logic        m_valid, m_stale;

  logic        obs_req, obs_valid;
  logic [31:0] obs_addr, obs_instr, obs_iaddr;
  logic [31:0] held, pend;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = 32'h0000_0100;
    m_redir = 32'h0;
    m_buf   = 32'h0;
    m_baddr = 32'h0;
    m_valid = 1'b0;
    m_stale = 1'b0;
    wcnt    = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1; hazardDetected_i = 1'b0; IFFlush_i = 1'b0;
    branchTarget_i = 32'h0; imemAck_i = 1'b0; imemData_i = 32'h0;
    #1;
    chk("rst_req",   {31'h0, imemReq_o},    32'h0);
    chk("rst_addr",  imemAddr_o,            32'h0);
    chk("rst_instr", instr_o,               32'h0);
    chk("rst_iaddr", instrAddr_o,           32'h0);
    chk("rst_valid", {31'h0, instrValid_o}, 32'h0);
    model_reset();
  endtask

  task automatic cycle(input logic h, input logic f, input logic [31:0] tgt);
    logic        m_req;
    logic [31:0] t;
    @(negedge clk_i);
    rst_i = 1'b0; hazardDetected_i = h; IFFlush_i = f; branchTarget_i = tgt;
    #1;
    imemAck_i  = imemReq_o && (wcnt >= ws);
    imemData_i = imemAck_i ? memf(imemAddr_o) : 32'h0;
    #1;
    obs_req = imemReq_o; obs_addr = imemAddr_o; obs_valid = instrValid_o;
    obs_instr = instr_o; obs_iaddr = instrAddr_o;
    m_req = !m_valid || !h;
    chk("req",   {31'h0, obs_req},   {31'h0, m_req});
    chk("addr",  obs_addr,           m_pc);
    chk("valid", {31'h0, obs_valid}, {31'h0, m_valid});
    chk("instr", obs_instr,          m_valid ? m_buf : 32'h0);
    chk("iaddr", obs_iaddr,          m_valid ? m_baddr : 32'h0);
    t = tgt & 32'hFFFF_FFFC;
    if (f) begin
      m_valid = 1'b0;
      if (m_req && !imemAck_i) begin
        m_stale = 1'b1;
        m_redir = t;
      end else begin
        m_pc    = t;
        m_stale = 1'b0;
      end
    end else if (m_stale) begin
      if (imemAck_i) begin
        m_pc    = m_redir;
        m_stale = 1'b0;
      end
    end else if (!(m_valid && h)) begin
      if (imemAck_i) begin
        m_valid = 1'b1;
        m_buf   = imemData_i;
        m_baddr = m_pc;
        m_pc    = m_pc + 32'd4;
      end else begin
        m_valid = 1'b0;
      end
    end
    if (imemReq_o && !imemAck_i) wcnt++;
    else wcnt = 0;
  endtask

  initial begin
    rst_i = 1'b1; hazardDetected_i = 1'b0; IFFlush_i = 1'b0;
    branchTarget_i = 32'h0; imemAck_i = 1'b0; imemData_i = 32'h0;

    // Zero-wait streaming from RESET_PC.
    ws = 0;
    do_reset();
    cycle(0, 0, 0);
    chk("p1_first_req", obs_addr, 32'h100);
    chk("p1_first_empty", {31'h0, obs_valid}, 32'h0);
    cycle(0, 0, 0);
    chk("p1_second_req", obs_addr, 32'h104);
    chk("p1_iaddr0", obs_iaddr, 32'h100);
    chk("p1_instr0", obs_instr, memf(32'h100));
    cycle(0, 0, 0);
    chk("p1_third_req", obs_addr, 32'h108);
    chk("p1_iaddr1", obs_iaddr, 32'h104);
    repeat (3) cycle(0, 0, 0);

    // Three wait states: address held four cycles, output bubble until after ack.
    ws = 3;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0);
      chk("p2_hold_addr", obs_addr, 32'h100);
      chk("p2_hold_empty", {31'h0, obs_valid}, 32'h0);
    end
    cycle(0, 0, 0);
    chk("p2_valid_after_ack", {31'h0, obs_valid}, 32'h1);
    chk("p2_iaddr", obs_iaddr, 32'h100);
    chk("p2_next_req", obs_addr, 32'h104);
    repeat (8) cycle(0, 0, 0);

    // Two-cycle stall in FULL.
    ws = 0;
    repeat (3) cycle(0, 0, 0);
    cycle(1, 0, 0);
    held = obs_iaddr;
    chk("p3_stall_req0", {31'h0, obs_req}, 32'h0);
    cycle(1, 0, 0);
    chk("p3_stall_req1", {31'h0, obs_req}, 32'h0);
    chk("p3_stall_hold", obs_iaddr, held);
    cycle(0, 0, 0);
    chk("p3_resume_same", obs_iaddr, held);
    cycle(0, 0, 0);
    chk("p3_resume_next", obs_iaddr, held + 32'd4);

    // Flush while a request waits: stale reply drained, then target fetched.
    ws = 2;
    for (int i = 0; i < 20 && wcnt != 1; i++) cycle(0, 0, 0);
    chk("p4_reach_wait", wcnt, 32'd1);
    pend = m_pc;
    cycle(0, 1, 32'h0000_0202);
    chk("p4_flush_addr_held", obs_addr, pend);
    cycle(0, 0, 0);
    chk("p4_drain_addr", obs_addr, pend);
    chk("p4_drain_empty", {31'h0, obs_valid}, 32'h0);
    cycle(0, 0, 0);
    chk("p4_target_req", obs_addr, 32'h200);
    chk("p4_target_empty", {31'h0, obs_valid}, 32'h0);
    repeat (6) cycle(0, 0, 0);

    // Two flushes during DRAIN; latest target wins.
    ws = 3;
    for (int i = 0; i < 20 && wcnt != 1; i++) cycle(0, 0, 0);
    chk("p5_reach_wait", wcnt, 32'd1);
    cycle(0, 1, 32'h0000_0300);
    cycle(0, 1, 32'h0000_0400);
    chk("p5_drain_empty", {31'h0, obs_valid}, 32'h0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("p5_latest_target", obs_addr, 32'h400);

    // Flush together with stall in FULL.
    ws = 0;
    repeat (3) cycle(0, 0, 0);
    cycle(1, 1, 32'h0000_0500);
    chk("p5_stallflush_req", {31'h0, obs_req}, 32'h0);
    cycle(0, 0, 0);
    chk("p5_flush_cleared", {31'h0, obs_valid}, 32'h0);
    chk("p5_flush_addr", obs_addr, 32'h500);
    cycle(0, 0, 0);
    chk("p5_flush_fetched", obs_iaddr, 32'h500);

    // PC wrap at the top of the address space.
    cycle(0, 1, 32'hFFFF_FFF8);
    cycle(0, 0, 0);
    chk("p6_addr_fff8", obs_addr, 32'hFFFF_FFF8);
    cycle(0, 0, 0);
    chk("p6_addr_fffc", obs_addr, 32'hFFFF_FFFC);
    cycle(0, 0, 0);
    chk("p6_wrap_zero", obs_addr, 32'h0);
    chk("p6_iaddr_fffc", obs_iaddr, 32'hFFFF_FFFC);

    // Reset in the middle of a wait zeroes outputs at once, then restarts at RESET_PC.
    ws = 3;
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    do_reset();
    cycle(0, 0, 0);
    chk("p6_restart_addr", obs_addr, 32'h100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
